// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, row debounce, key decode and a 16-bit history of codes.
// Define KEYPAD_AUTOREPEAT_EN to re-emit a held key every REPEAT_CYC cycles.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int REPEAT_CYC   = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  cols,
  input  logic [3:0]  rows,
  input  logic        clear,
  output logic [15:0] data,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);

  if (SCAN_DIV < 1 || DEBOUNCE_CYC < 1 || REPEAT_CYC < 1) begin : g_param_check
    $error("keypad_scanner: all cycle counts must be at least 1");
  end

  logic [3:0]        sync1_q, sync2_q;
  logic [1:0]        state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DEB_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        pat_q, pat_d;
  logic [15:0]       data_q, data_d;
  logic [3:0]        code_q, code_d;
  logic              valid_q, valid_d;
  logic              accept;
  logic              rep_fire;
  logic [3:0]        accept_code;

  function automatic logic [1:0] low_row(input logic [3:0] r);
    low_row = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) low_row = 2'(i);
    end
  endfunction

  // Code is 4*row + col, so it is simply the row and column indices concatenated.
  assign accept_code = {low_row(pat_q), col_q};

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

  logic [REP_W-1:0] rep_q, rep_d;

  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (state_q != ST_PRESSED) begin
      rep_d = '0;
    end else if (sync2_q != 4'hF) begin
      if (rep_q == REP_LAST) begin
        rep_d    = '0;
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    col_d   = col_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    code_d  = code_q;
    valid_d = 1'b0;
    data_d  = data_q;
    accept  = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (sync2_q == 4'hF) begin
            col_d = col_q + 2'd1;
          end else begin
            state_d = ST_DEBOUNCE;
            pat_d   = sync2_q;
            cnt_d   = '0;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (sync2_q != pat_q) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          tick_d  = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (sync2_q == 4'hF) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else if (rep_fire) begin
          accept = 1'b1;
        end
      end
      default: begin
        // Release: any contact restarts the quiet-time count without leaving the state.
        if (sync2_q != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_SCAN;
          tick_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    if (accept) begin
      code_d  = accept_code;
      valid_d = 1'b1;
      data_d  = {data_q[11:0], accept_code};
    end
    if (clear) data_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      tick_q  <= '0;
      cnt_q   <= '0;
      pat_q   <= 4'hF;
      data_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= rows;
      sync2_q <= sync1_q;
      state_q <= state_d;
      col_q   <= col_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign cols      = ~(4'b0001 << col_q);
  assign data      = data_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad matrix drives rows from cols, and a
// behavioural model of scan/debounce/history is compared against the outputs on every cycle.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 8;
  localparam int RC = 32;

  localparam int PH_SCAN   = 0;
  localparam int PH_SETTLE = 1;
  localparam int PH_HELD   = 2;
  localparam int PH_LETGO  = 3;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int          F_PULSES = 4;
  localparam logic [15:0] F_DATA   = 16'hFFFF;
`else
  localparam int          F_PULSES = 1;
  localparam logic [15:0] F_DATA   = 16'h004F;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  cols, rows;
  logic [15:0] data;
  logic [3:0]  key_code;
  logic        key_valid;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_total = 0;

  // Model state
  int         m_phase, m_col, m_tick, m_run, m_rep;
  logic [3:0] m_s1, m_s2, m_pat, m_code;
  logic       m_valid, m_acc_next;
  logic [3:0] m_hist[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC), .REPEAT_CYC(RC)) dut (
    .clk(clk), .rst(rst), .cols(cols), .rows(rows), .clear(clear),
    .data(data), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row line to its column line; rows and cols are active-low.
  function automatic logic [3:0] rows_of(input logic [3:0] c, input logic [15:0] k);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (!c[ci] && k[4*ri+ci]) r[ri] = 1'b0;
    return r;
  endfunction

  assign rows = rows_of(cols, keys);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] code_of(input logic [3:0] pat, input int col);
    int row;
    row = 3;
    for (int r = 3; r >= 0; r--) if (!pat[r]) row = r;
    return 4'(4 * row + col);
  endfunction

  function automatic logic [15:0] model_data();
    logic [15:0] d;
    d = '0;
    foreach (m_hist[i]) d = {d[11:0], m_hist[i]};
    return d;
  endfunction

  function automatic logic [3:0] model_cols();
    return 4'hF ^ (4'h1 << m_col);
  endfunction

  task automatic model_reset();
    m_phase = PH_SCAN; m_col = 0; m_tick = 0; m_run = 0; m_rep = 0;
    m_s1 = 4'hF; m_s2 = 4'hF; m_pat = 4'hF; m_code = 4'h0;
    m_valid = 1'b0; m_acc_next = 1'b0;
    m_hist.delete();
  endtask

  // Advances the model across the next rising edge, using the inputs as they stand now.
  task automatic model_step();
    logic [3:0] rs;
    bit fire;
    rs = m_s2;
    fire = 1'b0;
    m_valid = 1'b0;
    case (m_phase)
      PH_SCAN: begin
        m_tick++;
        if (m_tick == SD) begin
          m_tick = 0;
          if (rs == 4'hF) m_col = (m_col + 1) % 4;
          else begin m_phase = PH_SETTLE; m_pat = rs; m_run = 0; end
        end
      end
      PH_SETTLE: begin
        if (rs != m_pat) begin
          m_phase = PH_SCAN; m_col = (m_col + 1) % 4; m_tick = 0;
        end else begin
          m_run++;
          if (m_run == DC) begin m_phase = PH_HELD; m_rep = 0; fire = 1'b1; end
        end
      end
      PH_HELD: begin
        if (rs == 4'hF) begin m_phase = PH_LETGO; m_run = 0; end
`ifdef KEYPAD_AUTOREPEAT_EN
        else begin
          m_rep++;
          if (m_rep == RC) begin m_rep = 0; fire = 1'b1; end
        end
`endif
      end
      default: begin
        if (rs != 4'hF) m_run = 0;
        else begin
          m_run++;
          if (m_run == DC) begin m_phase = PH_SCAN; m_tick = 0; end
        end
      end
    endcase
    if (fire) begin
      m_code = code_of(m_pat, m_col);
      m_valid = 1'b1;
      m_hist.push_back(m_code);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
    end
    if (clear) m_hist.delete();
    m_s2 = m_s1;
    m_s1 = rows;
    m_acc_next = (m_phase == PH_SETTLE) && (m_s2 == m_pat) && (m_run == DC - 1);
  endtask

  always @(negedge clk) begin
    if (rst) model_reset();
    check("cycle {cols,data,code,valid}",
          {7'd0, cols, data, key_code, key_valid},
          {7'd0, model_cols(), model_data(), m_code, m_valid});
    if (!rst) model_step();
  end

  always @(negedge clk) if (key_valid === 1'b1) pulse_total++;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pulse(input string name, input int budget);
    int k;
    k = 0;
    while (key_valid !== 1'b1 && k < budget) begin tick(1); k++; end
    check(name, {31'd0, key_valid}, 32'd1);
  endtask

  task automatic press_release(input int code, input int hold, input int gap);
    keys = 16'h1 << code;
    tick(hold);
    keys = '0;
    tick(gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got still running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int p0;
    int found;
    rst = 1'b1; keys = '0; clear = 1'b0;
    tick(3);
    check("rst_cols", {28'd0, cols}, 32'hE);
    check("rst_data", {16'd0, data}, 32'h0);
    check("rst_valid", {31'd0, key_valid}, 32'h0);
    rst = 1'b0;

    // Idle scan: column n/4 is driven n edges after reset release.
    for (int n = 0; n < 20; n++) begin
      check("scan_cols", {28'd0, cols}, {28'd0, 4'hF ^ (4'h1 << ((n / 4) % 4))});
      if (n == 1) begin
        check("post_rst_data", {16'd0, data}, 32'h0);
        check("post_rst_valid", {31'd0, key_valid}, 32'h0);
      end
      tick(1);
    end

    // Clean press of key 6 (row 1, column 2)
    p0 = pulse_total;
    keys = 16'h1 << 6;
    wait_pulse("press6_seen", 40);
    check("press6_code", {28'd0, key_code}, 32'h6);
    tick(30);
    check("press6_pulses", pulse_total - p0, 1);
    check("press6_data", {16'd0, data}, 32'h0006);
    check("model_press6_data", {16'd0, model_data()}, 32'h0006);
    keys = '0;
    tick(30);

    // Sequence 1,2,3,A
    p0 = pulse_total;
    press_release(1, 40, 30);
    press_release(2, 40, 30);
    press_release(3, 40, 30);
    press_release(10, 40, 30);
    check("seq_pulses", pulse_total - p0, 4);
    check("seq_data", {16'd0, data}, 32'h123A);
    check("model_seq_data", {16'd0, model_data()}, 32'h123A);
    check("seq_code", {28'd0, key_code}, 32'hA);

    // Short glitches at several phase offsets never produce a key
    p0 = pulse_total;
    for (int off = 0; off < 4; off++) begin
      tick(off);
      keys = 16'h1 << 9;
      tick(3);
      keys = '0;
      tick(30);
    end
    check("glitch_pulses", pulse_total - p0, 0);

    // Release with a 2-cycle bounce
    p0 = pulse_total;
    keys = 16'h1 << 7;
    wait_pulse("bounce_seen", 40);
    tick(20);
    keys = '0;
    tick(5);
    keys = 16'h1 << 7;
    tick(2);
    keys = '0;
    tick(40);
    check("bounce_pulses", pulse_total - p0, 1);

    // Clear on the acceptance edge of key 5
    keys = 16'h1 << 5;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      tick(1);
      if (m_acc_next) begin clear = 1'b1; found = 1; break; end
    end
    check("clr_window", found, 1);
    tick(1);
    clear = 1'b0;
    check("clr_data", {16'd0, data}, 32'h0);
    check("clr_code", {28'd0, key_code}, 32'h5);
    check("clr_valid", {31'd0, key_valid}, 32'h1);
    tick(20);
    keys = '0;
    tick(30);

    // Reset during debounce of key 8; the held key is detected afresh
    keys = 16'h1 << 8;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (m_phase == PH_SETTLE) break;
    end
    check("deb_reached", m_phase, PH_SETTLE);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    wait_pulse("deb_rst_fresh", 40);
    check("deb_rst_code", {28'd0, key_code}, 32'h8);
    check("deb_rst_data", {16'd0, data}, 32'h0008);
    tick(10);
    keys = '0;
    tick(30);

    // Reset while key 4 is held
    keys = 16'h1 << 4;
    wait_pulse("hold_seen", 40);
    tick(5);
    rst = 1'b1;
    #1;
    check("hold_rst_cols", {28'd0, cols}, 32'hE);
    check("hold_rst_data", {16'd0, data}, 32'h0);
    check("hold_rst_valid", {31'd0, key_valid}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("hold_rel_cols", {28'd0, cols}, 32'hE);
    check("hold_rel_valid", {31'd0, key_valid}, 32'h0);
    p0 = pulse_total;
    wait_pulse("hold_fresh", 40);
    tick(5);
    check("hold_fresh_pulses", pulse_total - p0, 1);
    check("hold_fresh_data", {16'd0, data}, 32'h0004);
    keys = '0;
    tick(30);

    // Key F held for 100 cycles after acceptance
    p0 = pulse_total;
    keys = 16'h1 << 15;
    wait_pulse("f_seen", 40);
    tick(100);
    keys = '0;
    tick(30);
    check("f_pulses", pulse_total - p0, F_PULSES);
    check("f_data", {16'd0, data}, {16'd0, F_DATA});
    check("model_f_data", {16'd0, model_data()}, {16'd0, F_DATA});

    // Random presses, multi-key chords and clears
    for (int it = 0; it < 40; it++) begin
      int hold, gap, k1, k2;
      k1 = $urandom_range(0, 15);
      keys = 16'h1 << k1;
      if ($urandom_range(0, 4) == 0) begin
        k2 = $urandom_range(0, 15);
        keys[k2] = 1'b1;
      end
      hold = $urandom_range(0, 50);
      gap = $urandom_range(0, 40);
      if ($urandom_range(0, 7) == 0) begin
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
      end
      tick(hold);
      keys = '0;
      tick(gap);
    end
    tick(40);
    check("final_data", {16'd0, data}, {16'd0, model_data()});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
